// File: rtl/shot_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shot_game_ctrl
//  Purpose  : Possession sequencer for the shot clock. It drives the counter
//             load/hold controls, keeps the BCD score and drives the buzzer.
//  Revision : 1.0  initial release
// ============================================================================
module shot_game_ctrl #(
  parameter int SHOT_POINTS  = 2,
  parameter int FLIGHT_TICKS = 3,
  parameter int BUZZ_TICKS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start_pulse,
  input  logic       shot_pulse,
  input  logic       made_pulse,
  input  logic       clock_zero,
  output logic       load,
  output logic       hold,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic       buzzer,
  output logic [1:0] state
);

  localparam logic [3:0] c_points = 4'(SHOT_POINTS);
  localparam logic [3:0] c_flight = 4'(FLIGHT_TICKS);
  localparam logic [3:0] c_buzz   = 4'(BUZZ_TICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    FLIGHT = 2'b10,
    BUZZ   = 2'b11
  } state_t;

  state_t     r_state, w_next;
  logic       r_load, r_load_d, r_hold, r_buzzer, r_fresh;
  logic [3:0] r_tens, r_ones, r_flight_cnt, r_buzz_cnt;

  logic       w_load, w_zero_ok, w_tick;
  logic [3:0] w_tens, w_ones, w_flight_cnt, w_buzz_cnt;
  logic [3:0] w_ones_sum, w_add_tens, w_add_ones;

  // Counter flag is stale in the load cycle and the one after it.
  assign w_zero_ok  = !r_load && !r_load_d;
  // Ticks landing on the first cycle of a new state are not counted.
  assign w_tick     = tick_1hz && !r_fresh;
  assign w_ones_sum = r_ones + c_points;

  always_comb begin
    w_add_tens = r_tens;
    w_add_ones = w_ones_sum;
    if (w_ones_sum >= 4'd10) begin
      if (r_tens == 4'd9) begin
        w_add_tens = 4'd9;
        w_add_ones = 4'd9;
      end else begin
        w_add_tens = r_tens + 4'd1;
        w_add_ones = w_ones_sum - 4'd10;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_tens       = r_tens;
    w_ones       = r_ones;
    w_flight_cnt = r_flight_cnt;
    w_buzz_cnt   = r_buzz_cnt;
    case (r_state)
      IDLE: begin
        if (start_pulse) begin
          w_next = ARMED;
          w_load = 1'b1;
        end
      end
      ARMED: begin
        if (start_pulse) begin
          w_load = 1'b1;
        end else if (shot_pulse) begin
          w_next       = FLIGHT;
          w_flight_cnt = 4'd0;
        end else if (clock_zero && w_zero_ok) begin
          w_next     = BUZZ;
          w_buzz_cnt = 4'd0;
        end
      end
      FLIGHT: begin
        if (start_pulse) begin
          w_next = ARMED;
          w_load = 1'b1;
        end else if (made_pulse) begin
          w_next = ARMED;
          w_load = 1'b1;
          w_tens = w_add_tens;
          w_ones = w_add_ones;
        end else if (w_tick) begin
          w_flight_cnt = r_flight_cnt + 4'd1;
          if (w_flight_cnt == c_flight) begin
            w_next = ARMED;
            w_load = 1'b1;
          end
        end
      end
      BUZZ: begin
        if (start_pulse) begin
          w_next = ARMED;
          w_load = 1'b1;
        end else if (w_tick) begin
          w_buzz_cnt = r_buzz_cnt + 4'd1;
          if (w_buzz_cnt == c_buzz) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_load       <= 1'b0;
      r_load_d     <= 1'b0;
      r_hold       <= 1'b0;
      r_buzzer     <= 1'b0;
      r_fresh      <= 1'b0;
      r_tens       <= 4'd0;
      r_ones       <= 4'd0;
      r_flight_cnt <= 4'd0;
      r_buzz_cnt   <= 4'd0;
    end else begin
      r_state      <= w_next;
      r_load       <= w_load;
      r_load_d     <= r_load;
      r_hold       <= (w_next == FLIGHT) || (w_next == BUZZ);
      r_buzzer     <= (w_next == BUZZ);
      r_fresh      <= (w_next != r_state);
      r_tens       <= w_tens;
      r_ones       <= w_ones;
      r_flight_cnt <= w_flight_cnt;
      r_buzz_cnt   <= w_buzz_cnt;
    end
  end

  assign load       = r_load;
  assign hold       = r_hold;
  assign buzzer     = r_buzzer;
  assign score_tens = r_tens;
  assign score_ones = r_ones;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_shot_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shot_game_ctrl
//  Purpose  : Directed scoreboard bench for shot_game_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shot_game_ctrl;

  logic       clk, rst;
  logic       tick_1hz, start_pulse, shot_pulse, made_pulse, clock_zero;
  logic       load, hold, buzzer;
  logic [3:0] score_tens, score_ones;
  logic [1:0] state;

  typedef struct {
    string       tag;
    logic [12:0] vec;   // {state, load, hold, buzzer, tens, ones}
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   exp_score = 0;

  shot_game_ctrl #(.SHOT_POINTS(2), .FLIGHT_TICKS(3), .BUZZ_TICKS(2)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start_pulse(start_pulse),
    .shot_pulse(shot_pulse), .made_pulse(made_pulse), .clock_zero(clock_zero),
    .load(load), .hold(hold), .score_tens(score_tens), .score_ones(score_ones),
    .buzzer(buzzer), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] mk_exp(input logic [1:0] s, input logic l,
                                         input logic h, input logic b);
    logic [3:0] t, o;
    t = 4'(exp_score / 10);
    o = 4'(exp_score % 10);
    return {s, l, h, b, t, o};
  endfunction

  task automatic push_exp(input string tag, input logic [1:0] s, input logic l,
                          input logic h, input logic b);
    exp_t e;
    e.tag = tag;
    e.vec = mk_exp(s, l, h, b);
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [12:0] obs;
    e   = sb.pop_front();
    obs = {state, load, hold, buzzer, score_tens, score_ones};
    n_vec++;
    assert (obs === e.vec) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
    end
  endtask

  // Drive one cycle of inputs, then compare the registered response.
  task automatic apply(input string tag, input logic st, input logic sh,
                       input logic mk, input logic tk, input logic cz,
                       input logic [1:0] s, input logic l, input logic h,
                       input logic b);
    push_exp(tag, s, l, h, b);
    start_pulse = st; shot_pulse = sh; made_pulse = mk;
    tick_1hz    = tk; clock_zero = cz;
    @(posedge clk); #1;
    start_pulse = 1'b0; shot_pulse = 1'b0; made_pulse = 1'b0;
    tick_1hz    = 1'b0; clock_zero = 1'b0;
    check_out();
  endtask

  initial begin
    rst = 1'b1;
    start_pulse = 1'b0; shot_pulse = 1'b0; made_pulse = 1'b0;
    tick_1hz    = 1'b0; clock_zero = 1'b0;
    #2;
    push_exp("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    check_out();
    #10 rst = 1'b0;
    @(posedge clk); #1;

    apply("start",      1,0,0,0,0, 2'd1, 1, 0, 0);
    apply("zero_load",  0,0,0,0,1, 2'd1, 0, 0, 0);
    apply("zero_after", 0,0,0,0,1, 2'd1, 0, 0, 0);
    apply("shot1",      0,1,0,0,0, 2'd2, 0, 1, 0);
    apply("idle_fl",    0,0,0,0,0, 2'd2, 0, 1, 0);
    apply("tick_fl",    0,0,0,1,0, 2'd2, 0, 1, 0);
    exp_score = 2;
    apply("made1",      0,0,1,0,0, 2'd1, 1, 0, 0);
    apply("armed_idle", 0,0,0,0,0, 2'd1, 0, 0, 0);
    apply("shot2",      0,1,0,0,0, 2'd2, 0, 1, 0);
    exp_score = 4;
    apply("made2",      0,0,1,0,0, 2'd1, 1, 0, 0);

    apply("miss_shot",  0,1,0,0,0, 2'd2, 0, 1, 0);
    apply("miss_idle",  0,0,0,0,0, 2'd2, 0, 1, 0);
    apply("miss_t1",    0,0,0,1,0, 2'd2, 0, 1, 0);
    apply("miss_t2",    0,0,0,1,0, 2'd2, 0, 1, 0);
    apply("miss_t3",    0,0,0,1,0, 2'd1, 1, 0, 0);

    apply("vio_wait1",  0,0,0,0,0, 2'd1, 0, 0, 0);
    apply("vio_wait2",  0,0,0,0,0, 2'd1, 0, 0, 0);
    apply("violation",  0,0,0,0,1, 2'd3, 0, 1, 1);
    apply("buzz_idle",  0,0,0,0,0, 2'd3, 0, 1, 1);
    apply("buzz_t1",    0,0,0,1,0, 2'd3, 0, 1, 1);
    apply("buzz_t2",    0,0,0,1,0, 2'd0, 0, 0, 0);
    apply("idle_ign",   0,1,1,1,1, 2'd0, 0, 0, 0);

    apply("restart",    1,0,0,0,0, 2'd1, 1, 0, 0);
    apply("sim_wait1",  0,0,0,0,0, 2'd1, 0, 0, 0);
    apply("sim_wait2",  0,0,0,0,0, 2'd1, 0, 0, 0);
    apply("shot_zero",  0,1,0,0,1, 2'd2, 0, 1, 0);
    apply("sim_idle",   0,0,0,0,0, 2'd2, 0, 1, 0);
    apply("sim_t1",     0,0,0,1,0, 2'd2, 0, 1, 0);
    apply("sim_t2",     0,0,0,1,0, 2'd2, 0, 1, 0);
    exp_score = 6;
    apply("made_t3",    0,0,1,1,0, 2'd1, 1, 0, 0);

    apply("ab_wait1",   0,0,0,0,0, 2'd1, 0, 0, 0);
    apply("ab_wait2",   0,0,0,0,0, 2'd1, 0, 0, 0);
    apply("ab_vio",     0,0,0,0,1, 2'd3, 0, 1, 1);
    apply("buzz_abort", 1,0,0,0,0, 2'd1, 1, 0, 0);

    while (exp_score < 98) begin
      apply("fill_shot", 0,1,0,0,0, 2'd2, 0, 1, 0);
      exp_score = exp_score + 2;
      apply("fill_made", 0,0,1,0,0, 2'd1, 1, 0, 0);
    end
    apply("sat_shot1",  0,1,0,0,0, 2'd2, 0, 1, 0);
    exp_score = 99;
    apply("sat_99",     0,0,1,0,0, 2'd1, 1, 0, 0);
    apply("sat_shot2",  0,1,0,0,0, 2'd2, 0, 1, 0);
    apply("sat_hold",   0,0,1,0,0, 2'd1, 1, 0, 0);

    apply("rst_shot",   0,1,0,0,0, 2'd2, 0, 1, 0);
    exp_score = 0;
    push_exp("async_rst", 2'd0, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1 check_out();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    apply("post_rst",   1,0,0,0,0, 2'd1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shot_game_ctrl.md
# shot_game_ctrl

Game-sequencing controller that sits directly upstream of the shot clock counter and display path. It consumes the debounced button and sensor pulses, the 1 Hz tick and the counter's `zero` flag. It produces the counter's `load` and `hold` controls, a two-digit BCD score for the display mux and a buzzer enable. It owns the possession flow: idle, shot clock running, ball in flight, violation buzzer.

## Interface
Parameters:
- `SHOT_POINTS`, 2: BCD points added per made shot; legal range 1..3.
- `FLIGHT_TICKS`, 3: `tick_1hz` pulses allowed in flight before the shot counts as a miss; range 1..15.
- `BUZZ_TICKS`, 2: `tick_1hz` pulses the buzzer stays on after a violation; range 1..15.

Ports:
- `clk` in 1: 100 MHz system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `tick_1hz` in 1: one-cycle pulse from the clock divider.
- `start_pulse` in 1: debounced one-cycle start/new-possession request.
- `shot_pulse` in 1: debounced one-cycle shot-release event.
- `made_pulse` in 1: debounced one-cycle hoop-sensor event.
- `clock_zero` in 1: shot clock counter reads 00.
- `load` out 1: one-cycle reload request to the shot clock counter.
- `hold` out 1: freeze the shot clock countdown; level signal.
- `score_tens` out 4: BCD tens digit of the score.
- `score_ones` out 4: BCD ones digit of the score.
- `buzzer` out 1: buzzer drive; level signal.
- `state` out 2: current state encoding, for debug LEDs.

## Operation
- States and `state` encodings: IDLE (00), ARMED (01), FLIGHT (10), BUZZ (11).
- IDLE
  - `start_pulse` moves to ARMED and issues `load`.
  - All other inputs are ignored.
- ARMED: shot clock is running and `hold` is 0. Priority order:
  1. `start_pulse`: reissue `load` and stay in ARMED.
  2. `shot_pulse`: go to FLIGHT, set `hold`=1 and clear the flight tick counter.
  3. `clock_zero`: go to BUZZ and clear the buzz tick counter. This is a violation.
  - A shot released in the same cycle as `clock_zero` counts as a shot, not a violation.
- Zero guard: `clock_zero` is ignored in the cycle `load` is high and in the cycle after it. This masks the stale zero flag while the counter reloads.
- FLIGHT: `hold`=1. Priority order:
  1. `start_pulse`: go to ARMED, issue `load`, no score change.
  2. `made_pulse`: add `SHOT_POINTS` to the score, go to ARMED, issue `load`.
  3. `tick_1hz`: increment the flight counter. When the count reaches `FLIGHT_TICKS`, the shot is a miss; go to ARMED and issue `load` (rebound reset).
  - `made_pulse` on the same cycle as the final tick counts as made.
  - `shot_pulse` and `clock_zero` are ignored.
- BUZZ: `buzzer`=1 and `hold`=1.
  - Each `tick_1hz` increments the buzz counter.
  - At `BUZZ_TICKS`, go to IDLE and deassert `buzzer`.
  - `start_pulse` aborts the buzz: go to ARMED and issue `load`.
- Score arithmetic (BCD):
  - ones' = ones + `SHOT_POINTS`.
  - If ones' ≥ 10: subtract 10 and increment tens.
  - Saturate at 99: if the result would exceed 99, the score becomes tens=9, ones=9.
  - The score is never invalid BCD.
- The score persists across possessions. Only `rst` clears it.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `load`:
  - Exactly one cycle high.
  - Asserted the cycle after the triggering input edge, together with the state update.
  - Never high on two consecutive cycles unless `start_pulse` arrives on consecutive cycles.
- `hold` and `buzzer` change in the same cycle as `state`.
- The score updates in the cycle `state` leaves FLIGHT on a make.
- Reset values: `state`=IDLE, `load`=0, `hold`=0, `buzzer`=0, `score_tens`=0, `score_ones`=0, all internal counters 0.
- Reset asserted mid-operation (any state) returns to these values immediately and asynchronously. The first post-reset cycle honours `start_pulse`.
- A `tick_1hz` coinciding with a state-entry cycle is not counted toward the new state's counter.

## Test plan
- **Reset:** reset, then `start_pulse` → `load` high 1 cycle, `state`=01, `hold`=0, score 00.
- **Two makes:** ARMED, `shot_pulse` then `made_pulse` after 1 tick → `hold` 1→0, one `load`, score 02. A second make → 04.
- **Miss:** ARMED, `shot_pulse`, then 3 ticks with no make → ARMED, one `load`, score unchanged.
- **Violation:** `clock_zero` while ARMED → BUZZ, `buzzer`=1 for exactly 2 ticks, then IDLE. `clock_zero` in the load cycle and the next cycle → no BUZZ.
- **Simultaneous events:** `shot_pulse` and `clock_zero` on the same cycle → FLIGHT. `made_pulse` on the third flight tick → score +2.
- **Saturation and reset:** preload score 98 with `SHOT_POINTS`=2, make → 99, make again → 99. Assert `rst` during FLIGHT → all outputs reset, score 00.
